// File: rtl/spi_dvga_rx_pkg.sv
// Shared definitions for the DVGA 3-wire control link (writer and receiver).
package spi_dvga_rx_pkg;

  localparam int unsigned DVGA_WIDTH = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one async pin, with one-clock rise/fall pulses.
module sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_dvga_rx.sv
// DVGA link receiver: oversampled sclk/sdata/sload, MSB-first shift, commit on sload rise.
module spi_dvga_rx
  import spi_dvga_rx_pkg::*;
#(
  parameter int unsigned WIDTH       = DVGA_WIDTH,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sclk,
  input  logic             sdata,
  input  logic             sload,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 2);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic sdata_lvl, sdata_rise, sdata_fall;
  logic sload_lvl, sload_rise, sload_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk (
    .clock(clock), .reset_n(reset_n), .d(sclk),
    .q(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sdata (
    .clock(clock), .reset_n(reset_n), .d(sdata),
    .q(sdata_lvl), .rise(sdata_rise), .fall(sdata_fall));

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sload (
    .clock(clock), .reset_n(reset_n), .d(sload),
    .q(sload_lvl), .rise(sload_rise), .fall(sload_fall));

  logic unused_edges;
  assign unused_edges = ^{sclk_lvl, sclk_fall, sdata_rise, sdata_fall};

  state_t            state, state_n;
  logic              armed, armed_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [WIDTH-1:0]  shift, shift_n;
  logic [TMR_W-1:0]  timer, timer_n;
  logic [WIDTH-1:0]  data_n;
  logic              valid_n, err_n;
  logic [SYNC_STAGES:0] warm;

  // The sload chain resets high, so its level is not trusted for arming until
  // the pin has propagated through; otherwise a low pin at release could start a frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      armed      <= 1'b0;
      bit_cnt    <= '0;
      shift      <= '0;
      timer      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      warm       <= '0;
    end else begin
      state      <= state_n;
      armed      <= armed_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      timer      <= timer_n;
      data       <= data_n;
      data_valid <= valid_n;
      frame_err  <= err_n;
      warm       <= {warm[SYNC_STAGES-1:0], 1'b1};
    end
  end

  always_comb begin
    state_n   = state;
    armed_n   = armed | (sload_lvl & warm[SYNC_STAGES]);
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    timer_n   = '0;
    data_n    = data;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sload_fall && armed) begin
          state_n   = ST_SHIFT;
          armed_n   = 1'b0;
          bit_cnt_n = '0;
        end
      end
      ST_SHIFT: begin
        timer_n = timer + 1'b1;
        if (sclk_rise) begin
          shift_n = {shift[WIDTH-2:0], sdata_lvl};
          if (bit_cnt != CNT_SAT) bit_cnt_n = bit_cnt + 1'b1;
          timer_n = '0;
        end
        // Commit sees the bit shifted in this same cycle via the next-values.
        if (sload_rise) begin
          state_n = ST_IDLE;
          timer_n = '0;
          if (bit_cnt_n == CNT_FULL) begin
            data_n  = shift_n;
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end else if (!sclk_rise && timer == TMR_MAX) begin
          state_n = ST_IDLE;
          timer_n = '0;
          err_n   = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_spi_dvga_rx.sv
// Scoreboard bench for spi_dvga_rx: directed frames, expected pulses queued, monitor compares.
module tb_spi_dvga_rx;

  localparam int TIMEOUT = 1023;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        sclk, sdata, sload;
  logic [15:0] data;
  logic        data_valid, frame_err, busy;

  spi_dvga_rx #(.WIDTH(16), .SYNC_STAGES(2), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n), .sclk(sclk), .sdata(sdata), .sload(sload),
    .data(data), .data_valid(data_valid), .frame_err(frame_err), .busy(busy));

  always #5 clock = ~clock;

  typedef struct {
    bit          err;
    logic [15:0] d;
  } exp_t;

  exp_t        expq[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] model_data = 16'h0000;
  bit          prev_pulse = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_good(input logic [15:0] w);
    exp_t e;
    e.err = 1'b0; e.d = w;
    expq.push_back(e);
    model_data = w;
  endtask

  task automatic expect_err();
    exp_t e;
    e.err = 1'b1; e.d = model_data;
    expq.push_back(e);
  endtask

  task automatic send_bits(input logic [15:0] w, input int first, input int nbits, input bit same);
    for (int i = first; i < first + nbits; i++) begin
      sclk = 1'b0;
      sdata = (i < 16) ? w[15-i] : 1'b0;
      wait_clk(4);
      sclk = 1'b1;
      if (same && i == first + nbits - 1) break;
      wait_clk(4);
    end
  endtask

  task automatic send_frame(input logic [15:0] w, input int nbits, input bit same, input int gap);
    sload = 1'b0;
    wait_clk(4);
    send_bits(w, 0, nbits, same);
    sload = 1'b1;
    wait_clk(gap);
  endtask

  // Monitor: every pulse must match the head of the expected queue.
  always @(negedge clock) begin
    if (reset_n) begin
      if (data_valid || frame_err) begin
        check("pulse_exclusive", {31'b0, data_valid & frame_err}, 32'h0);
        check("pulse_width", {31'b0, prev_pulse}, 32'h0);
        if (expq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got valid=%0b err=%0b data=%0h expected none",
                   data_valid, frame_err, data);
        end else begin
          exp_t e;
          e = expq.pop_front();
          check("pulse_kind", {31'b0, frame_err}, {31'b0, e.err});
          check("data", {16'b0, data}, {16'b0, e.d});
        end
      end
      prev_pulse = data_valid | frame_err;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  initial begin
    reset_n = 1'b0; sclk = 1'b1; sdata = 1'b0; sload = 1'b1;
    wait_clk(3);
    check("rst_data", {16'b0, data}, 32'h0);
    check("rst_valid", {31'b0, data_valid}, 32'h0);
    check("rst_err", {31'b0, frame_err}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    reset_n = 1'b1;
    wait_clk(10);

    // 1: single good frame
    expect_good(16'h6B6B);
    send_frame(16'h6B6B, 16, 1'b0, 8);

    // 2: back-to-back with short sload-high gap
    expect_good(16'hAAAA);
    send_frame(16'hAAAA, 16, 1'b0, 3);
    expect_good(16'h5555);
    send_frame(16'h5555, 16, 1'b0, 8);
    check("b2b_final", {16'b0, data}, 32'h5555);

    // 3: short and long frames
    expect_err();
    send_frame(16'hFFFF, 15, 1'b0, 8);
    expect_err();
    send_frame(16'h0F0F, 17, 1'b0, 8);
    check("bad_len_keep", {16'b0, data}, 32'h5555);

    // 4: stalled frame, then stray sload rise, then good frame
    sload = 1'b0;
    wait_clk(4);
    send_bits(16'hFFFF, 0, 5, 1'b0);
    check("busy_mid", {31'b0, busy}, 32'h1);
    expect_err();
    wait_clk(TIMEOUT + 20);
    check("busy_timeout", {31'b0, busy}, 32'h0);
    sload = 1'b1;
    wait_clk(8);
    expect_good(16'h1234);
    send_frame(16'h1234, 16, 1'b0, 8);

    // 5: reset mid-frame, released with sload low
    sload = 1'b0;
    wait_clk(4);
    send_bits(16'hC3C3, 0, 8, 1'b0);
    reset_n = 1'b0;
    wait_clk(3);
    check("rst2_data", {16'b0, data}, 32'h0);
    check("rst2_busy", {31'b0, busy}, 32'h0);
    model_data = 16'h0000;
    reset_n = 1'b1;
    send_bits(16'hC3C3, 8, 8, 1'b0);
    check("rst2_ignored", {31'b0, busy}, 32'h0);
    sload = 1'b1;
    wait_clk(8);
    check("rst2_data_hold", {16'b0, data}, 32'h0);
    expect_good(16'hBEEF);
    send_frame(16'hBEEF, 16, 1'b0, 8);

    // 6: last sclk rise coincides with sload rise
    expect_good(16'hA5C3);
    send_frame(16'hA5C3, 16, 1'b1, 8);
    check("same_edge_data", {16'b0, data}, 32'hA5C3);

    wait_clk(20);
    check("queue_drained", expq.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
